// File: rtl/d_set_associative_cache.sv
// d_set_associative_cache: 2-way write-back/write-allocate L1 D-cache; define DCACHE_DEBUG_EN for event $display
module d_set_associative_cache #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH = 13,
  parameter int ADDRESS_WIDTH = 64,
  parameter int NUM_SETS = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic [ADDRESS_WIDTH-1:0] addr,
  input  logic enable,
  input  logic [1:0] rd_wr_evict_flag,
  output logic [BUS_DATA_WIDTH-1:0] read_data,
  output logic [1:0] data_available,
  output logic [1:0] canWrite,
  input  logic [BUS_DATA_WIDTH-1:0] write_data,
  output logic bus_reqcyc,
  output logic bus_respack,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0] bus_reqtag,
  input  logic bus_respcyc,
  input  logic bus_reqack,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0] bus_resptag,
  output logic addr_data_abtr_reqcyc,
  input  logic addr_data_abtr_grant,
  output logic store_data_abtr_reqcyc,
  input  logic store_data_abtr_grant,
  output logic addr_data_bus_busy,
  output logic store_data_bus_busy
);
  localparam int IW = $clog2(NUM_SETS);
  localparam int TW = ADDRESS_WIDTH - 6 - IW;
  localparam logic [BUS_TAG_WIDTH-1:0] RD_TAG = BUS_TAG_WIDTH'(13'h1100);
  localparam logic [BUS_TAG_WIDTH-1:0] WR_TAG = BUS_TAG_WIDTH'(13'h0100);

  typedef enum logic [2:0] {IDLE, WB_ARB, WB_ADDR, WB_DATA, FILL_ARB, FILL_ADDR, FILL_DATA} state_t;
  state_t r_state, w_next;

  logic [NUM_SETS-1:0] r_valid [2];
  logic [NUM_SETS-1:0] r_dirty [2];
  logic [NUM_SETS-1:0] r_lru;
  logic [TW-1:0] r_tag [2][NUM_SETS];
  logic [BUS_DATA_WIDTH-1:0] r_data [2][NUM_SETS][8];
  logic [IW-1:0] r_idx;
  logic [TW-1:0] r_ftag;
  logic r_way, r_evict;
  logic [2:0] r_beat;

  logic [IW-1:0] w_idx;
  logic [TW-1:0] w_tag;
  logic w_m0, w_m1, w_present, w_hw, w_vic, w_vdirty;
  logic w_rd, w_wr, w_ev, w_idle, w_hit, w_miss, w_evd, w_evc, w_start;
  logic w_wb_beat, w_fill_beat, w_unused;
  logic [BUS_DATA_WIDTH-1:0] w_word;
  logic [ADDRESS_WIDTH-1:0] w_wb_base, w_fill_base;

  assign w_idx = addr[6 +: IW];
  assign w_tag = addr[ADDRESS_WIDTH-1 -: TW];
  assign w_m0 = r_valid[0][w_idx] && r_tag[0][w_idx] == w_tag;
  assign w_m1 = r_valid[1][w_idx] && r_tag[1][w_idx] == w_tag;
  assign w_present = w_m0 || w_m1;
  assign w_hw = w_m1;
  assign w_vic = r_lru[w_idx];
  assign w_vdirty = r_valid[w_vic][w_idx] && r_dirty[w_vic][w_idx];
  assign w_rd = enable && rd_wr_evict_flag == 2'd1;
  assign w_wr = enable && rd_wr_evict_flag == 2'd2;
  assign w_ev = enable && rd_wr_evict_flag == 2'd3;
  assign w_idle = r_state == IDLE;
  assign w_hit = (w_rd || w_wr) && w_present;
  assign w_miss = w_idle && (w_rd || w_wr) && !w_present;
  assign w_evd = w_idle && w_ev && w_present && r_dirty[w_hw][w_idx];
  assign w_evc = w_idle && w_ev && w_present && !r_dirty[w_hw][w_idx];
  assign w_start = w_miss || w_evd;
  assign w_wb_beat = r_state == WB_DATA && bus_reqack;
  assign w_fill_beat = r_state == FILL_DATA && bus_respcyc;
  assign w_word = r_data[w_hw][w_idx][addr[5:3]];
  assign w_wb_base = {r_tag[r_way][r_idx], r_idx, 6'b0};
  assign w_fill_base = {r_ftag, r_idx, 6'b0};
  assign w_unused = ^bus_resptag;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      w_next = w_miss ? (w_vdirty ? WB_ARB : FILL_ARB) : w_evd ? WB_ARB : IDLE;
      WB_ARB:    w_next = store_data_abtr_grant ? WB_ADDR : WB_ARB;
      WB_ADDR:   w_next = bus_reqack ? WB_DATA : WB_ADDR;
      WB_DATA:   w_next = w_wb_beat && r_beat == 3'd7 ? (r_evict ? IDLE : FILL_ARB) : WB_DATA;
      FILL_ARB:  w_next = addr_data_abtr_grant ? FILL_ADDR : FILL_ARB;
      FILL_ADDR: w_next = bus_reqack ? FILL_DATA : FILL_ADDR;
      FILL_DATA: w_next = w_fill_beat && r_beat == 3'd7 ? IDLE : FILL_DATA;
      default:   w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_valid[0] <= '0;
      r_valid[1] <= '0;
      r_dirty[0] <= '0;
      r_dirty[1] <= '0;
      r_lru <= '0;
      r_idx <= '0;
      r_ftag <= '0;
      r_way <= 1'b0;
      r_evict <= 1'b0;
      r_beat <= '0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_idx <= w_idx;
        r_ftag <= w_tag;
        r_way <= w_ev ? w_hw : w_vic;
        r_evict <= w_ev;
        r_beat <= '0;
      end
      if (w_idle && w_hit) r_lru[w_idx] <= ~w_hw;
      if (w_idle && w_hit && w_wr) r_dirty[w_hw][w_idx] <= 1'b1;
      if (w_evc) r_valid[w_hw][w_idx] <= 1'b0;
      if (w_wb_beat || w_fill_beat) r_beat <= r_beat + 3'd1;
      if (w_wb_beat && r_beat == 3'd7 && r_evict) begin
        r_valid[r_way][r_idx] <= 1'b0;
        r_dirty[r_way][r_idx] <= 1'b0;
      end
      if (w_fill_beat && r_beat == 3'd7) begin
        r_valid[r_way][r_idx] <= 1'b1;
        r_dirty[r_way][r_idx] <= 1'b0;
      end
    end
  end

  // storage arrays carry no reset; valid bits alone decide what is live
  always_ff @(posedge clk) begin
    if (w_idle && w_hit && w_wr) r_data[w_hw][w_idx][addr[5:3]] <= write_data;
    if (w_fill_beat) r_data[r_way][r_idx][r_beat] <= bus_resp;
    if (w_fill_beat && r_beat == 3'd7) r_tag[r_way][r_idx] <= r_ftag;
  end

  always_comb begin
    bus_reqcyc = 1'b0;
    bus_respack = 1'b0;
    bus_req = '0;
    bus_reqtag = '0;
    addr_data_abtr_reqcyc = 1'b0;
    store_data_abtr_reqcyc = 1'b0;
    addr_data_bus_busy = 1'b0;
    store_data_bus_busy = 1'b0;
    data_available = 2'd0;
    canWrite = 2'd0;
    read_data = '0;
    if (!reset) begin
      bus_reqcyc = r_state == WB_ADDR || r_state == WB_DATA || r_state == FILL_ADDR;
      bus_respack = w_fill_beat;
      bus_req = r_state == WB_ADDR ? BUS_DATA_WIDTH'(w_wb_base) :
                r_state == WB_DATA ? r_data[r_way][r_idx][r_beat] :
                r_state == FILL_ADDR ? BUS_DATA_WIDTH'(w_fill_base) : '0;
      bus_reqtag = r_state == FILL_ADDR ? RD_TAG : (r_state == WB_ADDR || r_state == WB_DATA) ? WR_TAG : '0;
      addr_data_abtr_reqcyc = r_state == FILL_ARB;
      store_data_abtr_reqcyc = r_state == WB_ARB;
      addr_data_bus_busy = (r_state == FILL_ARB && addr_data_abtr_grant) || r_state == FILL_ADDR || r_state == FILL_DATA;
      store_data_bus_busy = (r_state == WB_ARB && store_data_abtr_grant) || r_state == WB_ADDR || r_state == WB_DATA;
      data_available = w_rd ? (w_idle && w_present ? 2'd2 : 2'd1) : 2'd0;
      canWrite = (w_wr || w_ev) ? (w_idle && (w_wr ? w_present : !w_present) ? 2'd2 : 2'd1) : 2'd0;
      read_data = w_idle && w_rd && w_present ? w_word >> {addr[2:0], 3'b000} : '0;
    end
  end

`ifdef DCACHE_DEBUG_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_idle && w_hit) $display("dcache hit addr=%h set=%0d way=%0d", addr, w_idx, w_hw);
      if (w_miss) $display("dcache miss addr=%h set=%0d way=%0d", addr, w_idx, w_vic);
      if (r_state == WB_ADDR && bus_reqack) $display("dcache writeback addr=%h set=%0d way=%0d", w_wb_base, r_idx, r_way);
      if (w_idle && w_ev && w_present) $display("dcache evict addr=%h set=%0d way=%0d", addr, w_idx, w_hw);
      if (w_fill_beat && r_beat == 3'd7) $display("dcache fill done addr=%h set=%0d way=%0d resptag=%h", w_fill_base, r_idx, r_way, bus_resptag);
    end
  end
`else
`endif
endmodule

// File: tb/tb_d_set_associative_cache.sv
// tb_d_set_associative_cache: scoreboard bench with bus/arbiter responders for the 2-way D-cache
module tb_d_set_associative_cache;
  logic clk = 1'b0;
  logic reset, enable;
  logic [63:0] addr, write_data, read_data, bus_req, bus_resp;
  logic [1:0] rd_wr_evict_flag, data_available, canWrite;
  logic bus_reqcyc, bus_respack, bus_respcyc, bus_reqack;
  logic [12:0] bus_reqtag, bus_resptag;
  logic addr_data_abtr_reqcyc, addr_data_abtr_grant, store_data_abtr_reqcyc, store_data_abtr_grant;
  logic addr_data_bus_busy, store_data_bus_busy;

  typedef struct packed {logic [63:0] req; logic [12:0] tag; logic wb;} bus_t;
  typedef struct packed {logic [1:0] flag; logic [63:0] rd;} resp_t;
  bus_t q_bus[$];
  resp_t q_resp[$];
  logic [511:0] q_fill[$];
  int n_checks = 0;
  int n_fail = 0;
  int fill_beat = 0;
  bit abort_fill = 1'b0;

  d_set_associative_cache dut (
    .clk(clk), .reset(reset), .addr(addr), .enable(enable), .rd_wr_evict_flag(rd_wr_evict_flag),
    .read_data(read_data), .data_available(data_available), .canWrite(canWrite), .write_data(write_data),
    .bus_reqcyc(bus_reqcyc), .bus_respack(bus_respack), .bus_req(bus_req), .bus_reqtag(bus_reqtag),
    .bus_respcyc(bus_respcyc), .bus_reqack(bus_reqack), .bus_resp(bus_resp), .bus_resptag(bus_resptag),
    .addr_data_abtr_reqcyc(addr_data_abtr_reqcyc), .addr_data_abtr_grant(addr_data_abtr_grant),
    .store_data_abtr_reqcyc(store_data_abtr_reqcyc), .store_data_abtr_grant(store_data_abtr_grant),
    .addr_data_bus_busy(addr_data_bus_busy), .store_data_bus_busy(store_data_bus_busy)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] mk(input logic [63:0] s);
    logic [511:0] l;
    for (int i = 0; i < 8; i++) l[i*64 +: 64] = s * 64'(i + 1);
    return l;
  endfunction

  function automatic logic [511:0] put(input logic [511:0] l, input int w, input logic [63:0] v);
    logic [511:0] r;
    r = l;
    r[w*64 +: 64] = v;
    return r;
  endfunction

  task automatic expect_fill(input logic [63:0] base, input logic [511:0] line);
    bus_t e;
    e.req = base; e.tag = 13'h1100; e.wb = 1'b0;
    q_bus.push_back(e);
    q_fill.push_back(line);
  endtask

  task automatic expect_wb(input logic [63:0] base, input logic [511:0] line);
    bus_t e;
    e.req = base; e.tag = 13'h0100; e.wb = 1'b1;
    q_bus.push_back(e);
    for (int i = 0; i < 8; i++) begin
      e.req = line[i*64 +: 64];
      q_bus.push_back(e);
    end
  endtask

  function automatic bit done();
    return rd_wr_evict_flag == 2'd1 ? data_available == 2'd2 : canWrite == 2'd2;
  endfunction

  task automatic access(input logic [1:0] f, input logic [63:0] a, input logic [63:0] wd, input logic [63:0] erd, input bit miss);
    resp_t r;
    int n;
    n = 0;
    r.flag = f; r.rd = erd;
    q_resp.push_back(r);
    @(posedge clk); #1;
    enable = 1'b1; rd_wr_evict_flag = f; addr = a; write_data = wd;
    @(negedge clk);
    check("first_status", 64'(f == 2'd1 ? data_available : canWrite), miss ? 64'd1 : 64'd2);
    while (!done() && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      n_checks++; n_fail++;
      $display("FAIL access_timeout: addr %h still pending after %0d cycles, required completion", a, n);
    end
    @(posedge clk); #1;
    enable = 1'b0; rd_wr_evict_flag = 2'd0;
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    check({name, "_bus_req"}, bus_req, 64'd0);
    check({name, "_read_data"}, read_data, 64'd0);
    check({name, "_ctl"}, 64'({bus_reqcyc, bus_respack, bus_reqtag, addr_data_abtr_reqcyc, store_data_abtr_reqcyc,
                               addr_data_bus_busy, store_data_bus_busy, data_available, canWrite}), 64'd0);
  endtask

  // arbiters grant after one cycle of request; bus accepts requests immediately
  initial begin
    bit ra, rs;
    ra = 1'b0; rs = 1'b0;
    addr_data_abtr_grant = 1'b0; store_data_abtr_grant = 1'b0; bus_reqack = 1'b0;
    forever begin
      @(posedge clk); #1;
      addr_data_abtr_grant = addr_data_abtr_reqcyc && ra;
      store_data_abtr_grant = store_data_abtr_reqcyc && rs;
      ra = addr_data_abtr_reqcyc;
      rs = store_data_abtr_reqcyc;
      bus_reqack = bus_reqcyc;
    end
  end

  initial begin
    logic [511:0] line;
    bus_respcyc = 1'b0; bus_resp = '0; bus_resptag = '0;
    forever begin
      @(negedge clk);
      if (bus_reqcyc && bus_reqack && bus_reqtag[12]) begin
        line = q_fill.size() != 0 ? q_fill.pop_front() : '0;
        for (int i = 0; i < 8; i++) begin
          @(posedge clk); #1;
          if (abort_fill) break;
          bus_respcyc = 1'b1;
          bus_resp = line[i*64 +: 64];
          fill_beat = i;
        end
        if (!abort_fill) begin
          @(posedge clk); #1;
        end
        bus_respcyc = 1'b0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (bus_reqcyc && bus_reqack) begin
      if (q_bus.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL bus_unexpected: got req %h tag %h, required no request", bus_req, bus_reqtag);
      end else begin
        bus_t e;
        e = q_bus.pop_front();
        check("bus_req", bus_req, e.req);
        check("bus_reqtag", 64'(bus_reqtag), 64'(e.tag));
        check("bus_busy", 64'({store_data_bus_busy, addr_data_bus_busy}), e.wb ? 64'd2 : 64'd1);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (enable && (data_available == 2'd2 || canWrite == 2'd2)) begin
      if (q_resp.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL resp_unexpected: got status %0d/%0d, required none", data_available, canWrite);
      end else begin
        resp_t e;
        e = q_resp.pop_front();
        check("done_status", 64'({data_available, canWrite}), e.flag == 2'd1 ? 64'h8 : 64'h2);
        if (e.flag == 2'd1) check("read_data", read_data, e.rd);
      end
    end
  end

  initial begin
    logic [511:0] l1, l2, l3, l4, l5, l6;
    int n;
    reset = 1'b1; enable = 1'b0; rd_wr_evict_flag = 2'd0; addr = '0; write_data = '0;
    l1 = mk(64'h11); l2 = mk(64'h202); l3 = mk(64'h303); l5 = mk(64'h505); l6 = mk(64'h606);
    l4 = put(mk(64'h404), 0, 64'h8877665544332211);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_idle("reset");
    expect_fill(64'h1000, l1);
    access(2'd1, 64'h1000, 0, 64'h11, 1'b1);
    expect_fill(64'h4040, l4);
    access(2'd1, 64'h4044, 0, 64'h88776655, 1'b1);
    access(2'd1, 64'h1018, 0, 64'h44, 1'b0);
    access(2'd2, 64'h1008, 64'hDEAD, 0, 1'b0);
    access(2'd1, 64'h1008, 0, 64'hDEAD, 1'b0);
    access(2'd2, 64'h1008, 64'hDEAD, 0, 1'b0);
    expect_fill(64'h2000, l2);
    access(2'd1, 64'h2008, 0, 64'h404, 1'b1);
    expect_wb(64'h1000, put(l1, 1, 64'hDEAD));
    expect_fill(64'h3000, l3);
    access(2'd1, 64'h3008, 0, 64'h606, 1'b1);
    check_idle("after_wb");
    expect_fill(64'h1000, l1);
    access(2'd1, 64'h1000, 0, 64'h11, 1'b1);
    access(2'd2, 64'h1010, 64'h55AA, 0, 1'b0);
    expect_wb(64'h1000, put(l1, 2, 64'h55AA));
    access(2'd3, 64'h1000, 0, 0, 1'b1);
    expect_fill(64'h1000, l5);
    access(2'd1, 64'h1000, 0, 64'h505, 1'b1);
    access(2'd3, 64'h2000, 0, 0, 1'b0);
    access(2'd3, 64'h1000, 0, 0, 1'b1);
    expect_fill(64'h1000, l1);
    access(2'd1, 64'h1020, 0, 64'h55, 1'b1);
    expect_fill(64'h6080, l6);
    @(posedge clk); #1;
    enable = 1'b1; rd_wr_evict_flag = 2'd1; addr = 64'h6080;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus_respcyc && fill_beat == 3) && n < 300);
    check("beat3_reached", 64'(n >= 300), 64'd0);
    check("beat3_pending", 64'(data_available), 64'd1);
    reset = 1'b1; abort_fill = 1'b1; enable = 1'b0; rd_wr_evict_flag = 2'd0;
    @(posedge clk); #1;
    reset = 1'b0;
    check_idle("reset_mid_fill");
    abort_fill = 1'b0;
    expect_fill(64'h6080, l6);
    access(2'd1, 64'h6088, 0, 64'hC0C, 1'b1);
    expect_fill(64'h1000, l1);
    access(2'd1, 64'h1000, 0, 64'h11, 1'b1);
    check_idle("final");
    repeat (4) @(negedge clk);
    check("bus_queue_left", 64'(q_bus.size()), 64'd0);
    check("resp_queue_left", 64'(q_resp.size()), 64'd0);
    check("fill_queue_left", 64'(q_fill.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
